// File: rtl/decode_issue_controller.sv
// Decode-stage issue controller: a 2-entry skid queue between fetch and decode.
// Each opcode is pre-decoded when it is pushed, so every D_* output comes from a register.
module decode_issue_controller #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        F_Valid,
  output logic        F_Ready,
  input  logic [31:0] F_Instr,
  input  logic [31:0] F_PC,
  input  logic        Stall_D,
  input  logic        Flush_D,
  output logic        D_Valid,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [2:0]  D_Imm_Type_Sel,
  output logic        D_Has_Imm,
  output logic        D_Illegal,
  output logic [1:0]  Occupancy,
  output logic [31:0] Issue_Count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned OCC_W = 2;

  localparam logic [SEL_W-1:0] IMM_I = SEL_W'(0);
  localparam logic [SEL_W-1:0] IMM_S = SEL_W'(1);
  localparam logic [SEL_W-1:0] IMM_B = SEL_W'(2);
  localparam logic [SEL_W-1:0] IMM_U = SEL_W'(3);
  localparam logic [SEL_W-1:0] IMM_J = SEL_W'(4);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]  instr;
    logic [XLEN-1:0]  pc;
    logic [SEL_W-1:0] imm_sel;
    logic             has_imm;
    logic             illegal;
  } entry_t;

  localparam entry_t EMPTY_ENTRY = '{
    instr:   NOP_INSTR,
    pc:      '0,
    imm_sel: IMM_I,
    has_imm: 1'b0,
    illegal: 1'b0
  };

  state_t            state, state_next;
  entry_t            head, head_next;
  entry_t            tail, tail_next;
  entry_t            fetch_entry;
  logic              push, pop;
  logic              valid_next, ready_next;
  logic [OCC_W-1:0]  occ_next;
  logic [XLEN-1:0]   count_next;

  assign push = F_Valid && F_Ready;
  assign pop  = D_Valid && !Stall_D;

  // Opcode pre-decode of the incoming word.
  always_comb begin
    fetch_entry         = EMPTY_ENTRY;
    fetch_entry.instr   = F_Instr;
    fetch_entry.pc      = F_PC;
    fetch_entry.has_imm = 1'b1;
    unique case (F_Instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0001111: fetch_entry.imm_sel = IMM_I;
      7'b0100011:             fetch_entry.imm_sel = IMM_S;
      7'b1100011:             fetch_entry.imm_sel = IMM_B;
      7'b0110111, 7'b0010111: fetch_entry.imm_sel = IMM_U;
      7'b1101111:             fetch_entry.imm_sel = IMM_J;
      7'b0110011:             fetch_entry.has_imm = 1'b0;
      default: begin
        fetch_entry.has_imm = 1'b0;
        fetch_entry.illegal = 1'b1;
      end
    endcase
  end

  // Next state and next register contents.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    count_next = Issue_Count;
    if (Flush_D) begin
      state_next = ST_EMPTY;
      head_next  = EMPTY_ENTRY;
    end else begin
      if (pop) count_next = Issue_Count + XLEN'(1);
      unique case (state)
        ST_EMPTY: begin
          if (push) begin
            state_next = ST_ONE;
            head_next  = fetch_entry;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            head_next  = fetch_entry;
          end else if (push) begin
            state_next = ST_TWO;
            tail_next  = fetch_entry;
          end else if (pop) begin
            state_next = ST_EMPTY;
            head_next  = EMPTY_ENTRY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_next = ST_ONE;
            head_next  = tail;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          head_next  = EMPTY_ENTRY;
        end
      endcase
    end
    valid_next = (state_next != ST_EMPTY);
    ready_next = (state_next != ST_TWO);
    occ_next   = OCC_W'(state_next);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_EMPTY;
      head        <= EMPTY_ENTRY;
      tail        <= EMPTY_ENTRY;
      D_Valid     <= 1'b0;
      F_Ready     <= 1'b1;
      Occupancy   <= '0;
      Issue_Count <= '0;
    end else begin
      state       <= state_next;
      head        <= head_next;
      tail        <= tail_next;
      D_Valid     <= valid_next;
      F_Ready     <= ready_next;
      Occupancy   <= occ_next;
      Issue_Count <= count_next;
    end
  end

  assign D_Instr        = head.instr;
  assign D_PC           = head.pc;
  assign D_Imm_Type_Sel = head.imm_sel;
  assign D_Has_Imm      = head.has_imm;
  assign D_Illegal      = head.illegal;

endmodule

// File: tb/tb_decode_issue_controller.sv
// Bench for decode_issue_controller: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_decode_issue_controller;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        F_Valid, F_Ready;
  logic [31:0] F_Instr, F_PC;
  logic        Stall_D, Flush_D;
  logic        D_Valid;
  logic [31:0] D_Instr, D_PC;
  logic [2:0]  D_Imm_Type_Sel;
  logic        D_Has_Imm, D_Illegal;
  logic [1:0]  Occupancy;
  logic [31:0] Issue_Count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       mq[$];
  logic [31:0] m_count;

  decode_issue_controller #(.NOP_INSTR(32'h0000_0013)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .F_Valid(F_Valid), .F_Ready(F_Ready), .F_Instr(F_Instr), .F_PC(F_PC),
    .Stall_D(Stall_D), .Flush_D(Flush_D),
    .D_Valid(D_Valid), .D_Instr(D_Instr), .D_PC(D_PC),
    .D_Imm_Type_Sel(D_Imm_Type_Sel), .D_Has_Imm(D_Has_Imm), .D_Illegal(D_Illegal),
    .Occupancy(Occupancy), .Issue_Count(Issue_Count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode: {imm_sel[2:0], has_imm, illegal}.
  function automatic logic [4:0] ref_decode(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    if (op == 7'h13 || op == 7'h03 || op == 7'h67 || op == 7'h73 || op == 7'h0F) return {3'd0, 2'b10};
    if (op == 7'h23) return {3'd1, 2'b10};
    if (op == 7'h63) return {3'd2, 2'b10};
    if (op == 7'h37 || op == 7'h17) return {3'd3, 2'b10};
    if (op == 7'h6F) return {3'd4, 2'b10};
    if (op == 7'h33) return {3'd0, 2'b00};
    return {3'd0, 2'b01};
  endfunction

  task automatic compare_all(input string tag);
    logic [31:0] ei, ep;
    logic [4:0]  d;
    if (mq.size() > 0) begin
      ei = mq[0].instr;
      ep = mq[0].pc;
      d  = ref_decode(ei);
    end else begin
      ei = 32'h0000_0013;
      ep = 32'h0;
      d  = 5'b0;
    end
    check({tag, ".valid"}, 32'(D_Valid), 32'(mq.size() > 0));
    check({tag, ".instr"}, D_Instr, ei);
    check({tag, ".pc"}, D_PC, ep);
    check({tag, ".sel"}, 32'(D_Imm_Type_Sel), 32'(d[4:2]));
    check({tag, ".has_imm"}, 32'(D_Has_Imm), 32'(d[1]));
    check({tag, ".illegal"}, 32'(D_Illegal), 32'(d[0]));
    check({tag, ".occ"}, 32'(Occupancy), 32'(mq.size()));
    check({tag, ".ready"}, 32'(F_Ready), 32'(mq.size() != 2));
    check({tag, ".count"}, Issue_Count, m_count);
  endtask

  // One cycle: drive at negedge, update the model, sample 1ns after the edge.
  task automatic step(input string tag, input logic fv, input logic [31:0] instr,
                      input logic [31:0] pc, input logic st, input logic fl);
    bit do_push, do_pop;
    @(negedge CLK);
    F_Valid = fv; F_Instr = instr; F_PC = pc; Stall_D = st; Flush_D = fl;
    do_push = fv && (mq.size() != 2);
    do_pop  = (mq.size() > 0) && !st;
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        m_count = m_count + 32'd1;
      end
      if (do_push) mq.push_back('{instr: instr, pc: pc});
    end
    @(posedge CLK);
    #1;
    compare_all(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  initial begin
    RST_N = 1'b0; F_Valid = 1'b0; F_Instr = '0; F_PC = '0; Stall_D = 1'b0; Flush_D = 1'b0;
    m_count = '0;
    #12;
    check("rst.valid", 32'(D_Valid), 32'd0);
    check("rst.instr", D_Instr, 32'h0000_0013);
    check("rst.ready", 32'(F_Ready), 32'd1);
    check("rst.count", Issue_Count, 32'd0);
    RST_N = 1'b1;

    // Single push then pop.
    step("push1", 1'b1, 32'h0050_0093, 32'h0000_0100, 1'b0, 1'b0);
    step("pop1",  1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Immediate-type sweep, one per cycle.
    step("sw_s",   1'b1, 32'h0011_2223, 32'h0000_0200, 1'b0, 1'b0);
    step("sw_b",   1'b1, 32'h0020_8463, 32'h0000_0204, 1'b0, 1'b0);
    step("sw_u",   1'b1, 32'h1234_50B7, 32'h0000_0208, 1'b0, 1'b0);
    step("sw_j",   1'b1, 32'h0080_00EF, 32'h0000_020C, 1'b0, 1'b0);
    step("sw_r",   1'b1, 32'h0020_81B3, 32'h0000_0210, 1'b0, 1'b0);
    step("sw_ill", 1'b1, 32'h2A2A_2A2A, 32'h0000_0214, 1'b0, 1'b0);
    step("sw_dr",  1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Fill under stall: third push refused, head held.
    step("stf1", 1'b1, 32'h0000_0113, 32'h0000_0300, 1'b1, 1'b0);
    step("stf2", 1'b1, 32'h0000_0193, 32'h0000_0304, 1'b1, 1'b0);
    step("stf3", 1'b1, 32'h0000_0213, 32'h0000_0308, 1'b1, 1'b0);
    step("stf4", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step("stf5", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Flush with a simultaneous push while full.
    step("fl1", 1'b1, 32'h0000_0293, 32'h0000_0400, 1'b1, 1'b0);
    step("fl2", 1'b1, 32'h0000_0313, 32'h0000_0404, 1'b1, 1'b0);
    step("fl3", 1'b1, 32'hDEAD_0393, 32'h0000_0408, 1'b0, 1'b1);
    step("fl4", 1'b1, 32'h0000_0413, 32'h0000_040C, 1'b1, 1'b0);

    // Asynchronous reset while full.
    step("ar1", 1'b1, 32'h0000_0493, 32'h0000_0410, 1'b1, 1'b0);
    #2 RST_N = 1'b0;
    #1;
    mq.delete();
    m_count = '0;
    compare_all("arst");
    @(negedge CLK);
    F_Valid = 1'b0; Stall_D = 1'b0;
    RST_N = 1'b1;

    // Issue_Count wrap.
    step("wr1", 1'b1, 32'h0000_0513, 32'h0000_0500, 1'b1, 1'b0);
    #1 force dut.Issue_Count = 32'hFFFF_FFFF;
    #1 release dut.Issue_Count;
    m_count = 32'hFFFF_FFFF;
    step("wrap", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rnd", ($urandom_range(0, 9) < 7), rand_instr(), $urandom,
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
